// File: rtl/md5_stream_ctrl.sv
// MD5 stream controller: fetches 256-bit ROM words, pads and chains blocks
// through the external MD5 core. Optional digest compare: MD5_DIGEST_CMP_EN.
module md5_stream_ctrl #(
  parameter int          ROM_AW = 10,
  parameter int          LEN_W  = 11,
  parameter logic [31:0] IV_A   = 32'h67452301,
  parameter logic [31:0] IV_B   = 32'hefcdab89,
  parameter logic [31:0] IV_C   = 32'h98badcfe,
  parameter logic [31:0] IV_D   = 32'h10325476
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [127:0]      expected,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [255:0]      rom_data,
  output logic              core_rstb,
  output logic [31:0]       core_a_in,
  output logic [31:0]       core_b_in,
  output logic [31:0]       core_c_in,
  output logic [31:0]       core_d_in,
  output logic [511:0]      core_msg,
  input  logic [31:0]       core_a,
  input  logic [31:0]       core_b,
  input  logic [31:0]       core_c,
  input  logic [31:0]       core_d,
  input  logic              core_done,
  output logic              busy,
  output logic              done,
  output logic [127:0]      digest,
  output logic              match
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH0, S_CAP0, S_CAP1, S_ODD,
    S_LAUNCH, S_WAIT, S_UPDATE, S_FIN
  } state_t;

  state_t r_state, w_next;

  logic [ROM_AW-1:0] r_ptr, r_addr;
  logic [LEN_W-1:0]  r_len, r_rem;
  logic [31:0]       r_a, r_b, r_c, r_d;
  logic [511:0]      r_msg;
  logic [127:0]      r_digest;
  logic              r_final, r_busy, r_done;
  logic              w_rd;
  logic [63:0]       w_bitlen;

  assign w_bitlen = 64'(r_len) << 8;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH0;
      S_FETCH0: begin
        if (r_rem == '0) begin
          w_next = S_LAUNCH;
        end else begin
          w_rd   = 1'b1;
          w_next = (r_rem == LEN_W'(1)) ? S_ODD : S_CAP0;
        end
      end
      S_CAP0: begin
        w_rd   = 1'b1;
        w_next = S_CAP1;
      end
      S_CAP1:   w_next = S_LAUNCH;
      S_ODD:    w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (core_done) w_next = S_UPDATE;
      S_UPDATE: w_next = r_final ? S_FIN : S_FETCH0;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // address is only presented on read cycles, otherwise the last one holds
  assign rom_addr  = w_rd ? r_ptr : r_addr;
  assign core_rstb = (r_state != S_LAUNCH);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr    <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_rem    <= '0;
      r_a      <= IV_A;
      r_b      <= IV_B;
      r_c      <= IV_C;
      r_d      <= IV_D;
      r_msg    <= '0;
      r_digest <= '0;
      r_final  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_rd) begin
        r_ptr  <= r_ptr + ROM_AW'(1);
        r_addr <= r_ptr;
      end
      unique case (r_state)
        S_IDLE: if (start) begin
          r_ptr   <= base_addr;
          r_len   <= len_words;
          r_rem   <= len_words;
          r_a     <= IV_A;
          r_b     <= IV_B;
          r_c     <= IV_C;
          r_d     <= IV_D;
          r_final <= 1'b0;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
        S_FETCH0: if (r_rem == '0) begin
          r_msg   <= {w_bitlen, 416'b0, 32'h00000080};
          r_final <= 1'b1;
        end
        S_CAP0: r_msg[255:0] <= rom_data;
        S_CAP1: begin
          r_msg[511:256] <= rom_data;
          r_rem          <= r_rem - LEN_W'(2);
        end
        S_ODD: begin
          r_msg   <= {w_bitlen, 160'b0, 32'h00000080, rom_data};
          r_final <= 1'b1;
        end
        S_UPDATE: begin
          r_a <= core_a;
          r_b <= core_b;
          r_c <= core_c;
          r_d <= core_d;
          if (r_final) r_digest <= {core_a, core_b, core_c, core_d};
        end
        S_FIN: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign core_a_in = r_a;
  assign core_b_in = r_b;
  assign core_c_in = r_c;
  assign core_d_in = r_d;
  assign core_msg  = r_msg;
  assign busy      = r_busy;
  assign done      = r_done;
  assign digest    = r_digest;

`ifdef MD5_DIGEST_CMP_EN
  logic r_match;
  always_ff @(posedge Clk) begin
    if (Reset)                        r_match <= 1'b0;
    else if (r_state == S_IDLE && start) r_match <= 1'b0;
    else if (r_state == S_FIN)        r_match <= (r_digest == expected);
  end
  assign match = r_match;
`else
  logic w_unused;
  assign w_unused = ^expected;
  assign match    = 1'b0;
`endif

endmodule

// File: doc/md5_stream_ctrl.md
Name: md5_stream_ctrl

Overview:
- Parametrised successor to the single-purpose MD5 core controller. Hashes a message of programmable length, counted in 256-bit words, read from a block ROM starting at a programmable base address.
- Forms standard MD5 512-bit blocks, applies RFC 1321 padding and length, chains A/B/C/D across blocks, and sequences the MD5_6Stage core.
- Sits between the content ROM and the integrity-check logic. Reports the 128-bit digest and an optional compare result.

Parameters:
- ROM_AW, 10, ROM address width.
- LEN_W, 11, width of the message-length input in 256-bit words; must be > ROM_AW.
- IV_A, 32'h67452301, initial chaining value A.
- IV_B, 32'hefcdab89, initial chaining value B.
- IV_C, 32'h98badcfe, initial chaining value C.
- IV_D, 32'h10325476, initial chaining value D.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ROM_AW  first ROM word; latched on start.
- len_words  in  LEN_W  message length in 256-bit words; latched on start.
- expected  in  128  reference digest {A,B,C,D}.
- rom_addr  out  ROM_AW  ROM address; data returns 1 cycle later.
- rom_data  in  256  ROM read data.
- core_rstb  out  1  active-low start pulse to the core.
- core_a_in, core_b_in, core_c_in, core_d_in  out  32 each  chaining inputs to the core.
- core_msg  out  512  block to the core; word k = core_msg[32k+31:32k].
- core_a, core_b, core_c, core_d  in  32 each  core result; already includes the chaining add.
- core_done  in  1  core end-of-computation flag.
- busy  out  1  high from the start accept until done.
- done  out  1  level; set at completion, cleared by the next accepted start.
- digest  out  128  {A,B,C,D} final result.
- match  out  1  digest == expected; valid while done = 1.

Behaviour:
- Reset values: busy=0, done=0, digest=0, match=0, core_rstb=1, rom_addr=0, core_msg=0. Chaining registers load IV_A..IV_D.
- States:
  - IDLE: on start, latch base_addr and len_words, load the IVs into the chaining registers, set remaining = len_words, busy=1, done=0, go to FETCH0. A start seen in any other state is ignored.
  - FETCH0
    - If remaining >= 2: drive rom_addr = ptr, ptr++, go to CAP0.
    - If remaining == 1: fetch one word, then build the final odd block.
    - If remaining == 0: build the pad block directly (no ROM read) and go to LAUNCH.
  - CAP0: capture rom_data into msg[255:0]; drive rom_addr = ptr, ptr++, go to CAP1.
  - CAP1: capture msg[511:256], remaining -= 2, go to LAUNCH.
  - Odd final block:
    - msg[255:0] = data; word 8 = 32'h00000080; words 9-13 = 0.
    - word 14 = bitlen[31:0]; word 15 = bitlen[63:32].
    - bitlen = len_words*256, zero-extended to 64 bits.
    - After this block, final is set.
  - Pad block (len_words even, including 0):
    - word 0 = 32'h00000080; words 1-13 = 0; words 14/15 = bitlen.
    - The pad block is the final block.
  - LAUNCH: core_rstb=0 for exactly one cycle; core_msg and the chaining inputs are held stable from here until core_done. Go to WAIT.
  - WAIT: core_rstb=1; on core_done go to UPDATE.
  - UPDATE: chaining registers <= core outputs.
    - If final: digest <= core outputs, go to FIN.
    - Otherwise go to FETCH0.
  - FIN: done=1, busy=0, match registered; go to IDLE the next cycle.
- Block count: (len_words >> 1) full blocks + 1 final block.
- Pointer: ptr wraps modulo 2^ROM_AW with no error flag.
- Reset in any state: immediate return to IDLE with all reset values applied on the next edge. The core is not drained; it is restarted on the next launch.
- core_done asserted outside WAIT is ignored.

Optional Feature:
- Macro: MD5_DIGEST_CMP_EN.
- Defined: match = (digest == expected), registered in FIN and held until the next start.
- Undefined: no comparator is built and match is tied to 0; the expected input is ignored.

Test Plan:
- Empty message: Reset, start with len_words=0 -> no rom_addr activity, 1 core launch, digest = d41d8cd98f00b204e9800998ecf8427e, done=1, busy=0.
- Odd length: len_words=1, ROM[5]=0, base=5 -> 1 launch; core_msg word 8 = 00000080, word 14 = 00000100; digest equals the reference model.
- Even length: len_words=2 -> 2 launches; second block word 0 = 00000080, word 14 = 00000200; chaining inputs of block 2 equal the block-1 outputs.
- Wrap and busy: base=1023, len_words=3 -> rom_addr sequence 1023, 0, 1; a start pulsed during WAIT is ignored, with exactly 2 launches.
- Reset mid-hash: len_words=8, assert Reset during the third WAIT -> next cycle busy=0, core_rstb=1; a new start with len_words=1 hashes correctly from the IVs.
- With MD5_DIGEST_CMP_EN: expected = model digest -> match=1; flip expected bit 0 -> match=0. Without the macro: match=0 in both cases.
